// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave front end for spi_buffer.
// sclk/cs/mosi are oversampled into the clk domain. Words are shifted MSB
// first, and the transmit word is reloaded at every word boundary so the
// buffer can stream words back to back within one chip-select frame.
module spi_slave_driver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] data_to_send,
  output logic [DATA_WIDTH-1:0] data_received,
  output logic                  ready,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Synchroniser chains: [0] is stage 1, [1] is stage 2, [2] is the edge-detect history.
  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  // flush_q marks when the cs chain holds real samples rather than reset values.
  logic [1:0] flush_q;
  logic       armed_q;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tx_shreg_q, tx_shreg_d;
  logic [DATA_WIDTH-1:0]   rx_shreg_q, rx_shreg_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    reload_q, reload_d;
  logic                    ready_q, ready_d;

  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise, mosi_s;
  logic [DATA_WIDTH-1:0]   rx_next;

  // Input synchronisers, and arming: a frame may only start after cs has really been seen high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q  <= '0;
      cs_q    <= '1;
      mosi_q  <= '0;
      flush_q <= '0;
      armed_q <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      cs_q    <= {cs_q[1:0], cs};
      mosi_q  <= {mosi_q[0], mosi};
      flush_q <= {flush_q[0], 1'b1};
      if (flush_q[1] && cs_q[1]) armed_q <= 1'b1;
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = ~cs_q[1] & cs_q[2] & armed_q;
  assign cs_rise   = cs_q[1] & ~cs_q[2];
  assign mosi_s    = mosi_q[1];
  assign rx_next   = {rx_shreg_q[DATA_WIDTH-2:0], mosi_s};

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_shreg_q <= '0;
      rx_shreg_q <= '0;
      rdata_q    <= '0;
      bit_cnt_q  <= '0;
      reload_q   <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_shreg_q <= tx_shreg_d;
      rx_shreg_q <= rx_shreg_d;
      rdata_q    <= rdata_d;
      bit_cnt_q  <= bit_cnt_d;
      reload_q   <= reload_d;
      ready_q    <= ready_d;
    end
  end

  // Next-state logic: cs rise outranks any simultaneous sclk edge.
  always_comb begin
    state_d    = state_q;
    tx_shreg_d = tx_shreg_q;
    rx_shreg_d = rx_shreg_q;
    rdata_d    = rdata_q;
    bit_cnt_d  = bit_cnt_q;
    reload_d   = reload_q;
    ready_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_shreg_d = data_to_send;
          bit_cnt_d  = '0;
          reload_d   = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          reload_d  = 1'b0;
        end else if (sclk_rise) begin
          rx_shreg_d = rx_next;
          if (bit_cnt_q == LAST_BIT) begin
            rdata_d   = rx_next;
            ready_d   = 1'b1;
            bit_cnt_d = '0;
            reload_d  = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            tx_shreg_d = data_to_send;
            reload_d   = 1'b0;
          end else begin
            tx_shreg_d = tx_shreg_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso          = (state_q == SHIFT) & tx_shreg_q[DATA_WIDTH-1];
  assign busy          = (state_q == SHIFT);
  assign ready         = ready_q;
  assign data_received = rdata_q;

endmodule

// File: tb/tb_spi_slave_driver.sv
// Directed + randomized bench for spi_slave_driver. The reference model is a
// pair of word queues: what the master sends (expected data_received) and
// what the buffer offers (expected miso bits, MSB first).
module tb_spi_slave_driver;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi;
  logic       miso, ready, busy;
  logic [7:0] data_to_send, data_received;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mw[$];   // words the master shifts in
  logic [7:0] sw[$];   // words the buffer presents, in order
  logic [7:0] last_rx;

  always #5 clk = ~clk;

  spi_slave_driver #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .data_to_send(data_to_send), .data_received(data_received),
    .ready(ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One chip-select frame of nbits bits with sclk half-period h. The buffer
  // model presents the next sw word one cycle after each ready pulse.
  task automatic frame(input int h, input int nbits, input bit rst_abort);
    int w, b;
    data_to_send = sw[0];
    tick();
    cs   = 1'b0;
    mosi = mw[0][7];
    for (int k = 0; k < nbits; k++) begin
      w = k / 8;
      b = 7 - (k % 8);
      if (k != 0) begin
        sclk = 1'b0;
        mosi = mw[w][b];
      end
      for (int c = 1; c <= h; c++) begin
        tick();
        chk("ready_low", 32'(ready), 32'(0));
      end
      if (k == 0) chk("busy_frame", 32'(busy), 32'(1));
      chk("miso_bit", 32'(miso), 32'(sw[w][b]));
      sclk = 1'b1;
      for (int c = 1; c <= h; c++) begin
        tick();
        chk("ready_pulse", 32'(ready), 32'(b == 0 && c == 3));
        if (b == 0 && c == 3) begin
          chk("rx_word", 32'(data_received), 32'(mw[w]));
          last_rx = mw[w];
        end
        if (b == 0 && c == 4 && w + 1 < sw.size()) data_to_send = sw[w+1];
      end
    end
    if (rst_abort) begin
      rst = 1'b1;
      #1;
      chk("rst_miso", 32'(miso), 32'(0));
      chk("rst_ready", 32'(ready), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_rdata", 32'(data_received), 32'(0));
      last_rx = 8'h00;
      tick();
      rst = 1'b0;
      // cs still low and sclk toggling: must not look like a new frame
      for (int t = 0; t < 4; t++) begin
        sclk = ~sclk;
        for (int c = 0; c < h; c++) begin
          tick();
          chk("post_rst_busy", 32'(busy), 32'(0));
          chk("post_rst_ready", 32'(ready), 32'(0));
        end
      end
      sclk = 1'b0;
      tick();
      cs = 1'b1;
      repeat (6) tick();
    end else begin
      sclk = 1'b0;
      for (int c = 1; c <= h; c++) begin
        tick();
        chk("ready_tail", 32'(ready), 32'(0));
      end
      cs = 1'b1;
      repeat (4) tick();
      chk("end_busy", 32'(busy), 32'(0));
      chk("end_miso", 32'(miso), 32'(0));
      chk("end_rdata", 32'(data_received), 32'(last_rx));
      chk("end_ready", 32'(ready), 32'(0));
    end
  endtask

  task automatic rand_words(input int n);
    mw.delete();
    sw.delete();
    for (int i = 0; i < n; i++) begin
      mw.push_back(8'($urandom));
      sw.push_back(8'($urandom));
    end
  endtask

  initial begin
    int nw;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; data_to_send = 8'h00;
    last_rx = 8'h00;
    repeat (3) tick();
    chk("reset_miso", 32'(miso), 32'(0));
    chk("reset_ready", 32'(ready), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_rdata", 32'(data_received), 32'(0));
    rst = 1'b0;
    repeat (5) tick();
    chk("release_busy", 32'(busy), 32'(0));

    // single word
    mw = '{8'h3C};
    sw = '{8'hA5};
    frame(6, 8, 1'b0);

    // back-to-back three words, buffer streams 11 22 33
    rand_words(3);
    sw = '{8'h11, 8'h22, 8'h33};
    frame(5, 24, 1'b0);

    // abort after 5 bits, then a clean frame
    rand_words(1);
    frame(4, 5, 1'b0);
    rand_words(1);
    mw = '{8'hF0};
    frame(4, 8, 1'b0);

    // idle noise
    for (int t = 0; t < 20; t++) begin
      sclk = ~sclk;
      mosi = 1'($urandom);
      repeat (4) tick();
      chk("idle_ready", 32'(ready), 32'(0));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_miso", 32'(miso), 32'(0));
    end
    chk("idle_rdata", 32'(data_received), 32'(last_rx));

    // reset mid-frame after 3 bits, then 5A intact
    rand_words(1);
    frame(5, 3, 1'b1);
    rand_words(1);
    mw = '{8'h5A};
    frame(5, 8, 1'b0);

    // minimum timing, two words
    rand_words(2);
    frame(4, 16, 1'b0);

    // randomized frames
    for (int f = 0; f < 4; f++) begin
      nw = int'($urandom_range(3, 1));
      rand_words(nw);
      frame(int'($urandom_range(8, 4)), nw * 8, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
